// File: rtl/fin_period_meter_if.sv
// Bus-side handshake and result bundle for one fin_period_meter channel.
// Suffixes follow the meter's view: _i driven by the bus master, _o by the meter.
interface fin_period_meter_if #(
    parameter int CNT_WIDTH = 30,
    parameter int PER_WIDTH = 24
);
    logic                 start_i;
    logic                 abort_i;
    logic [PER_WIDTH-1:0] target_i;
    logic                 busy_o;
    logic                 ready_o;
    logic [PER_WIDTH-1:0] periods_o;
    logic [CNT_WIDTH-1:0] ref_ticks_o;
    logic                 overflow_o;

    modport master (
        output start_i, abort_i, target_i,
        input  busy_o, ready_o, periods_o, ref_ticks_o, overflow_o
    );

    modport slave (
        input  start_i, abort_i, target_i,
        output busy_o, ready_o, periods_o, ref_ticks_o, overflow_o
    );
endinterface

// File: rtl/fin_period_meter.sv
// fin_period_meter: reciprocal period measurement for one Fin input bit.
// Counts clk_i ticks across an edge-aligned window of N whole fin_i periods.
//
// state   | meaning
// IDLE    | waiting for start_i
// ARM     | target latched, waiting for the first fin rise to open the window
// MEASURE | window open, counting ticks and fin rises
// DONE    | result registers loaded, ready_o high for this cycle only
module fin_period_meter #(
    parameter int CNT_WIDTH   = 30,
    parameter int PER_WIDTH   = 24,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              fin_i,
    fin_period_meter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ARM, MEASURE, DONE} state_t;
    localparam logic [CNT_WIDTH-1:0] TICK_MAX = '1;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   rise;

    state_t                 state_q;
    logic [PER_WIDTH-1:0]   tgt_q;
    logic [PER_WIDTH-1:0]   edges_q;
    logic [PER_WIDTH-1:0]   periods_q;
    logic [CNT_WIDTH-1:0]   ticks_q;
    logic [CNT_WIDTH-1:0]   ref_ticks_q;
    logic                   busy_q;
    logic                   ready_q;
    logic                   overflow_q;

    logic [CNT_WIDTH-1:0]   ticks_d;
    logic [PER_WIDTH-1:0]   edges_d;
    logic                   ticks_sat;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], fin_i};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise      = sync_q[SYNC_STAGES-1] & ~prev_q;
    assign ticks_d   = (ticks_q == TICK_MAX) ? TICK_MAX : ticks_q + CNT_WIDTH'(1);
    assign ticks_sat = (ticks_d == TICK_MAX);
    assign edges_d   = edges_q + PER_WIDTH'(1);

    // Results are loaded on the edge entering DONE so they are valid alongside ready_o.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= IDLE;
            tgt_q       <= '0;
            edges_q     <= '0;
            ticks_q     <= '0;
            periods_q   <= '0;
            ref_ticks_q <= '0;
            overflow_q  <= 1'b0;
            busy_q      <= 1'b0;
            ready_q     <= 1'b0;
        end else begin
            ready_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (bus.start_i) begin
                        tgt_q   <= (bus.target_i == '0) ? PER_WIDTH'(1) : bus.target_i;
                        ticks_q <= '0;
                        edges_q <= '0;
                        busy_q  <= 1'b1;
                        state_q <= ARM;
                    end
                end
                ARM: begin
                    if (bus.abort_i) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else if (rise) begin
                        ticks_q <= '0;
                        edges_q <= '0;
                        state_q <= MEASURE;
                    end else begin
                        ticks_q <= ticks_d;
                        if (ticks_sat) begin
                            periods_q   <= '0;
                            ref_ticks_q <= ticks_d;
                            overflow_q  <= 1'b1;
                            ready_q     <= 1'b1;
                            state_q     <= DONE;
                        end
                    end
                end
                MEASURE: begin
                    if (bus.abort_i) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        ticks_q <= ticks_d;
                        if (rise) edges_q <= edges_d;
                        if (rise && edges_d == tgt_q) begin
                            periods_q   <= edges_d;
                            ref_ticks_q <= ticks_d;
                            overflow_q  <= 1'b0;
                            ready_q     <= 1'b1;
                            state_q     <= DONE;
                        end else if (ticks_sat) begin
                            periods_q   <= rise ? edges_d : edges_q;
                            ref_ticks_q <= ticks_d;
                            overflow_q  <= 1'b1;
                            ready_q     <= 1'b1;
                            state_q     <= DONE;
                        end
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.busy_o      = busy_q;
    assign bus.ready_o     = ready_q;
    assign bus.periods_o   = periods_q;
    assign bus.ref_ticks_o = ref_ticks_q;
    assign bus.overflow_o  = overflow_q;
endmodule

// File: tb/tb_fin_period_meter.sv
// Self-checking bench for fin_period_meter: directed cases plus randomized
// periods/targets compared against an arithmetic reciprocal-count model.
module tb_fin_period_meter;
    localparam int CW   = 8;
    localparam int PW   = 8;
    localparam int TMAX = (1 << CW) - 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    logic fin   = 1'b0;

    always #5 clk = ~clk;

    fin_period_meter_if #(.CNT_WIDTH(CW), .PER_WIDTH(PW)) ifc ();

    fin_period_meter #(.CNT_WIDTH(CW), .PER_WIDTH(PW), .SYNC_STAGES(2)) dut (
        .clk_i (clk),
        .rst_i (rst_n),
        .fin_i (fin),
        .bus   (ifc)
    );

    // Periodic fin source, stepped once per clock on the falling edge.
    int fin_per = 8;
    int fin_hi  = 4;
    bit fin_en  = 1'b0;
    int fin_ph  = 0;
    always @(negedge clk) begin
        if (fin_en) begin
            fin_ph = (fin_ph + 1) % fin_per;
            fin    = (fin_ph < fin_hi);
        end else begin
            fin    = 1'b0;
        end
    end

    int ready_cnt = 0;
    always @(negedge clk) if (ifc.ready_o === 1'b1) ready_cnt++;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: a window of n whole periods spans n*per ticks unless the counter
    // tops out first, in which case only the rises seen by tick TMAX are reported.
    task automatic model(input int per, input int tgt, output int e_per, output int e_ticks,
                         output int e_ov);
        int n;
        n = (tgt == 0) ? 1 : tgt;
        if (n * per <= TMAX) begin
            e_per = n; e_ticks = n * per; e_ov = 0;
        end else begin
            e_per = TMAX / per; e_ticks = TMAX; e_ov = 1;
        end
    endtask

    task automatic set_fin(input int per, input int hi);
        fin_per = per;
        fin_hi  = hi;
        fin_en  = 1'b1;
        repeat (3 * per + int'($urandom % per)) @(negedge clk);
    endtask

    task automatic pulse_start(input int tgt, input bit with_abort);
        ifc.target_i = PW'(tgt);
        ifc.start_i  = 1'b1;
        ifc.abort_i  = with_abort;
        @(negedge clk);
        ifc.start_i  = 1'b0;
        ifc.abort_i  = 1'b0;
    endtask

    task automatic wait_ready(input string tag, output bit got, output int lat);
        got = 1'b0;
        lat = 0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (ifc.ready_o === 1'b1) begin
                got = 1'b1;
                lat = i + 1;
                break;
            end
        end
        check_val({tag, "_ready_seen"}, 32'(got), 1);
    endtask

    task automatic check_result(input string tag, input int e_p, input int e_t, input int e_o);
        check_val({tag, "_periods"},   32'(ifc.periods_o),   e_p);
        check_val({tag, "_ref_ticks"}, 32'(ifc.ref_ticks_o), e_t);
        check_val({tag, "_overflow"},  32'(ifc.overflow_o),  e_o);
    endtask

    task automatic run_meas(input string tag, input int per, input int hi, input int tgt,
                            input bit with_abort);
        int e_p, e_t, e_o, r0, lat;
        bit got;
        model(per, tgt, e_p, e_t, e_o);
        set_fin(per, hi);
        r0 = ready_cnt;
        pulse_start(tgt, with_abort);
        check_val({tag, "_busy_hi"}, 32'(ifc.busy_o), 1);
        wait_ready(tag, got, lat);
        if (got) check_result(tag, e_p, e_t, e_o);
        @(negedge clk);
        check_val({tag, "_busy_lo"}, 32'(ifc.busy_o), 0);
        check_val({tag, "_ready_count"}, 32'(ready_cnt - r0), 1);
    endtask

    initial begin
        int e_p, e_t, e_o, r0, lat, per, hi, tgt, n;
        bit got;
        ifc.start_i  = 1'b0;
        ifc.abort_i  = 1'b0;
        ifc.target_i = '0;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_val("rst_busy",  32'(ifc.busy_o), 0);
        check_val("rst_ready", 32'(ifc.ready_o), 0);
        check_result("rst", 0, 0, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run_meas("t1", 8, 4, 4, 1'b0);
        run_meas("t2", 10, 5, 0, 1'b0);

        // Dead input: the ARM-phase tick counter must end the measurement.
        fin_en = 1'b0;
        repeat (5) @(negedge clk);
        r0 = ready_cnt;
        pulse_start(3, 1'b0);
        wait_ready("t3", got, lat);
        if (got) begin
            check_result("t3", 0, TMAX, 1);
            check_val("t3_latency", 32'(lat), TMAX);
        end
        @(negedge clk);
        check_val("t3_ready_count", 32'(ready_cnt - r0), 1);

        // Re-pulsed start while busy must not restart or re-sample the target.
        model(8, 4, e_p, e_t, e_o);
        set_fin(8, 4);
        r0 = ready_cnt;
        pulse_start(4, 1'b0);
        repeat (10) @(negedge clk);
        pulse_start(9, 1'b0);
        wait_ready("t4", got, lat);
        if (got) check_result("t4", e_p, e_t, e_o);
        repeat (40) @(negedge clk);
        check_val("t4_ready_count", 32'(ready_cnt - r0), 1);

        // Abort mid-window: previous (t4) result must survive.
        set_fin(6, 3);
        r0 = ready_cnt;
        pulse_start(8, 1'b0);
        repeat (20) @(negedge clk);
        ifc.abort_i = 1'b1;
        @(negedge clk);
        ifc.abort_i = 1'b0;
        check_val("t5_busy_lo", 32'(ifc.busy_o), 0);
        repeat (60) @(negedge clk);
        check_val("t5_ready_count", 32'(ready_cnt - r0), 0);
        check_result("t5_keep", e_p, e_t, e_o);

        // Async reset between clock edges clears outputs without a clock.
        pulse_start(8, 1'b0);
        repeat (20) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_val("t6_busy_rst", 32'(ifc.busy_o), 0);
        check_result("t6_rst", 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_meas("t6_fresh", 6, 3, 2, 1'b0);

        // abort_i alongside start_i in IDLE: start wins.
        run_meas("t7_abort_start", 12, 6, 3, 1'b1);

        for (int k = 0; k < 12; k++) begin
            per = int'($urandom_range(40, 4));
            hi  = int'($urandom_range(per - 2, 2));
            tgt = int'($urandom_range(12, 0));
            n   = (tgt == 0) ? 1 : tgt;
            if (n * per == TMAX) per = per + 1;
            run_meas($sformatf("rnd%0d_p%0d_n%0d", k, per, tgt), per, hi, tgt, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
